// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Control FSM for a multi-cycle processor. Each instruction runs through
// FETCH -> DECODE -> EXEC and then, depending on its class, MEM and/or WB
// before returning to FETCH. All control outputs are registered: on every
// edge the FSM picks the next state and loads the control word that belongs
// to that state, so the outputs always describe the current state.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   instruction    current instruction register contents [18:0]
//   C, Z           registered carry / zero flags
//   mem_ready      data memory has finished the current access
//   ir_write       instruction register load enable
//   pc_write       PC load enable
//   pc_mux         PC source: 00 PC+1, 01 branch, 10 jump target, 11 return
//   mem_read       data memory read strobe
//   mem_write      data memory write strobe
//   reg_write      register file write enable
//   reg_write_mux  write-back source: 00 ALU, 01 shifter, 10 memory
//   push, pop      return-address stack controls
//   alu_in_mux     ALU operand A source (1 = immediate / address path)
//   reg_B_mux      register B address source
//   select_c/_z    flag source select (1 = shifter)
//   write_c/_z     flag register write enables
//   alu_use_carry  ALU consumes incoming carry
//   alu_op         ALU operation
//   state          current FSM state (debug)
//   stack_err      sticky stack overflow / underflow flag
//
// Handshake: the instruction, C and Z are expected to stay stable from the
// FETCH cycle until the FSM is back in FETCH. In MEM, the access completes
// on the first rising edge at which mem_ready is 1; mem_ready is ignored in
// every other state.
// ---------------------------------------------------------------------------
module multicycle_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [18:0] instruction,
    input  logic        C,
    input  logic        Z,
    input  logic        mem_ready,
    output logic        ir_write,
    output logic        pc_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        push,
    output logic        pop,
    output logic [1:0]  pc_mux,
    output logic [1:0]  reg_write_mux,
    output logic        alu_in_mux,
    output logic        reg_B_mux,
    output logic        select_c,
    output logic        select_z,
    output logic        write_c,
    output logic        write_z,
    output logic        alu_use_carry,
    output logic [2:0]  alu_op,
    output logic [2:0]  state,
    output logic        stack_err
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       push;
        logic       pop;
        logic [1:0] pc_mux;
        logic [1:0] reg_write_mux;
        logic       alu_in_mux;
        logic       reg_B_mux;
        logic       select_c;
        logic       select_z;
        logic       write_c;
        logic       write_z;
        logic       alu_use_carry;
        logic [2:0] alu_op;
    } ctrl_t;

    state_t     r_state;
    ctrl_t      r_ctrl;
    logic       r_run;      // 0 until the first edge after reset release
    logic [3:0] r_depth;    // return-address stack depth, 0..8
    logic       r_err;

    // ---------------- instruction decode ----------------
    logic w_is_arith, w_is_mem, w_is_branch, w_is_shift;
    logic w_is_jmp, w_is_jsb, w_is_ret, w_is_stm, w_taken;
    logic w_stack_full, w_stack_empty;
    logic w_unused;

    assign w_is_arith    = ~instruction[18];
    assign w_is_mem      = (instruction[18:16] == 3'b100);
    assign w_is_branch   = (instruction[18:16] == 3'b101);
    assign w_is_shift    = (instruction[18:16] == 3'b110);
    assign w_is_jmp      = (instruction[18:14] == 5'b11100);
    assign w_is_jsb      = (instruction[18:14] == 5'b11101);
    assign w_is_ret      = (instruction[18:13] == 6'b111100);
    assign w_is_stm      = instruction[14];
    // bit 15 picks the flag, bit 14 inverts the condition
    assign w_taken       = (instruction[15] ? C : Z) ^ instruction[14];
    assign w_stack_full  = (r_depth == 4'd8);
    assign w_stack_empty = (r_depth == 4'd0);
    assign w_unused      = ^instruction[12:0];

    // ---------------- per-state control words ----------------
    ctrl_t w_fetch_ctrl, w_exec_ctrl, w_mem_ctrl, w_wb_ctrl;

    always_comb begin
        w_fetch_ctrl          = '0;
        w_fetch_ctrl.ir_write = 1'b1;
        w_fetch_ctrl.pc_write = 1'b1;

        w_exec_ctrl = '0;
        if (w_is_arith) begin
            w_exec_ctrl.alu_op        = instruction[16:14];
            w_exec_ctrl.alu_use_carry = instruction[14];
            w_exec_ctrl.alu_in_mux    = instruction[17];
        end else if (w_is_mem) begin
            w_exec_ctrl.alu_in_mux = 1'b1;
            w_exec_ctrl.reg_B_mux  = 1'b1;
        end else if (w_is_branch) begin
            w_exec_ctrl.pc_write = w_taken;
            w_exec_ctrl.pc_mux   = w_taken ? 2'b01 : 2'b00;
        end else if (w_is_jmp) begin
            w_exec_ctrl.pc_write = 1'b1;
            w_exec_ctrl.pc_mux   = 2'b10;
        end else if (w_is_jsb && !w_stack_full) begin
            w_exec_ctrl.pc_write = 1'b1;
            w_exec_ctrl.pc_mux   = 2'b10;
            w_exec_ctrl.push     = 1'b1;
        end else if (w_is_ret && !w_stack_empty) begin
            w_exec_ctrl.pc_write = 1'b1;
            w_exec_ctrl.pc_mux   = 2'b11;
            w_exec_ctrl.pop      = 1'b1;
        end
        // shift, NOP and a stack fault leave EXEC idle

        w_mem_ctrl            = '0;
        w_mem_ctrl.alu_in_mux = 1'b1;
        w_mem_ctrl.reg_B_mux  = 1'b1;
        w_mem_ctrl.mem_write  = instruction[14];
        w_mem_ctrl.mem_read   = ~instruction[14];

        w_wb_ctrl           = '0;
        w_wb_ctrl.reg_write = 1'b1;
        if (w_is_arith) begin
            // ALU controls stay up so the result is still valid at write-back
            w_wb_ctrl.alu_op        = instruction[16:14];
            w_wb_ctrl.alu_use_carry = instruction[14];
            w_wb_ctrl.alu_in_mux    = instruction[17];
            w_wb_ctrl.write_c       = 1'b1;
            w_wb_ctrl.write_z       = 1'b1;
        end else if (w_is_shift) begin
            w_wb_ctrl.reg_write_mux = 2'b01;
            w_wb_ctrl.select_c      = 1'b1;
            w_wb_ctrl.select_z      = 1'b1;
            w_wb_ctrl.write_c       = 1'b1;
            w_wb_ctrl.write_z       = 1'b1;
        end else begin
            w_wb_ctrl.reg_write_mux = 2'b10;   // LDM
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_ctrl  <= '0;
            r_run   <= 1'b0;
            r_depth <= 4'd0;
            r_err   <= 1'b0;
        end else if (!r_run) begin
            // first edge after reset: FETCH with its strobes
            r_run   <= 1'b1;
            r_state <= S_FETCH;
            r_ctrl  <= w_fetch_ctrl;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_state <= S_DECODE;
                    r_ctrl  <= '0;
                end
                S_DECODE: begin
                    r_state <= S_EXEC;
                    r_ctrl  <= w_exec_ctrl;
                    // stack depth moves together with the push/pop strobes
                    if (w_is_jsb) begin
                        if (w_stack_full) r_err <= 1'b1;
                        else              r_depth <= r_depth + 4'd1;
                    end
                    if (w_is_ret) begin
                        if (w_stack_empty) r_err <= 1'b1;
                        else               r_depth <= r_depth - 4'd1;
                    end
                end
                S_EXEC: begin
                    if (w_is_arith || w_is_shift) begin
                        r_state <= S_WB;
                        r_ctrl  <= w_wb_ctrl;
                    end else if (w_is_mem) begin
                        r_state <= S_MEM;
                        r_ctrl  <= w_mem_ctrl;
                    end else begin
                        r_state <= S_FETCH;
                        r_ctrl  <= w_fetch_ctrl;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (w_is_stm) begin
                            r_state <= S_FETCH;
                            r_ctrl  <= w_fetch_ctrl;
                        end else begin
                            r_state <= S_WB;
                            r_ctrl  <= w_wb_ctrl;
                        end
                    end else begin
                        r_state <= S_MEM;
                        r_ctrl  <= w_mem_ctrl;
                    end
                end
                S_WB: begin
                    r_state <= S_FETCH;
                    r_ctrl  <= w_fetch_ctrl;
                end
                default: begin
                    r_state <= S_FETCH;
                    r_ctrl  <= w_fetch_ctrl;
                end
            endcase
        end
    end

    // ---------------- outputs ----------------
    assign ir_write      = r_ctrl.ir_write;
    assign pc_write      = r_ctrl.pc_write;
    assign mem_read      = r_ctrl.mem_read;
    assign mem_write     = r_ctrl.mem_write;
    assign reg_write     = r_ctrl.reg_write;
    assign push          = r_ctrl.push;
    assign pop           = r_ctrl.pop;
    assign pc_mux        = r_ctrl.pc_mux;
    assign reg_write_mux = r_ctrl.reg_write_mux;
    assign alu_in_mux    = r_ctrl.alu_in_mux;
    assign reg_B_mux     = r_ctrl.reg_B_mux;
    assign select_c      = r_ctrl.select_c;
    assign select_z      = r_ctrl.select_z;
    assign write_c       = r_ctrl.write_c;
    assign write_z       = r_ctrl.write_z;
    assign alu_use_carry = r_ctrl.alu_use_carry;
    assign alu_op        = r_ctrl.alu_op;
    assign state         = r_state;
    assign stack_err     = r_err;

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
//
// Self-checking bench. A reference model turns each instruction into the
// list of cycles it should produce (state, stack_err, control word, and the
// mem_ready value to drive in MEM cycles); the bench plays the instruction
// and compares the DUT cycle by cycle against that list.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic [18:0] instruction;
    logic        C, Z, mem_ready;
    logic        ir_write, pc_write, mem_read, mem_write, reg_write, push, pop;
    logic [1:0]  pc_mux, reg_write_mux;
    logic        alu_in_mux, reg_B_mux, select_c, select_z, write_c, write_z;
    logic        alu_use_carry;
    logic [2:0]  alu_op, state;
    logic        stack_err;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .instruction(instruction),
        .C(C), .Z(Z), .mem_ready(mem_ready),
        .ir_write(ir_write), .pc_write(pc_write),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .push(push), .pop(pop),
        .pc_mux(pc_mux), .reg_write_mux(reg_write_mux),
        .alu_in_mux(alu_in_mux), .reg_B_mux(reg_B_mux),
        .select_c(select_c), .select_z(select_z),
        .write_c(write_c), .write_z(write_z),
        .alu_use_carry(alu_use_carry), .alu_op(alu_op),
        .state(state), .stack_err(stack_err)
    );

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       push;
        logic       pop;
        logic [1:0] pc_mux;
        logic [1:0] reg_write_mux;
        logic       alu_in_mux;
        logic       reg_B_mux;
        logic       select_c;
        logic       select_z;
        logic       write_c;
        logic       write_z;
        logic       alu_use_carry;
        logic [2:0] alu_op;
    } ctl_t;

    typedef struct {
        logic [2:0] st;
        logic       err;
        ctl_t       ctl;
        logic       ready;
    } cyc_t;

    typedef struct {
        logic [18:0] instr;
        logic        c;
        logic        z;
        int          mem_cycles;
        int          exp_cycles;
        string       name;
    } vec_t;

    // ---------------- scoreboard ----------------
    cyc_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_depth;
    logic m_err;

    function automatic ctl_t dut_ctl();
        ctl_t r;
        r.ir_write = ir_write;       r.pc_write = pc_write;
        r.mem_read = mem_read;       r.mem_write = mem_write;
        r.reg_write = reg_write;     r.push = push;     r.pop = pop;
        r.pc_mux = pc_mux;           r.reg_write_mux = reg_write_mux;
        r.alu_in_mux = alu_in_mux;   r.reg_B_mux = reg_B_mux;
        r.select_c = select_c;       r.select_z = select_z;
        r.write_c = write_c;         r.write_z = write_z;
        r.alu_use_carry = alu_use_carry;
        r.alu_op = alu_op;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void add_cyc(input logic [2:0] st, input ctl_t c, input logic rdy);
        cyc_t r;
        r.st = st; r.err = m_err; r.ctl = c; r.ready = rdy;
        exp_q.push_back(r);
    endfunction

    task automatic model_instr(input logic [18:0] ins, input logic c, input logic z,
                               input int mem_cycles);
        ctl_t f, e, w, m;
        logic taken;
        f = '0; f.ir_write = 1'b1; f.pc_write = 1'b1;
        add_cyc(3'd0, f, 1'b0);
        add_cyc(3'd1, '0, 1'b0);
        e = '0;
        if (ins[18:17] == 2'b00 || ins[18:17] == 2'b01) begin
            // arithmetic: EXEC then WB
            e.alu_op = ins[16:14]; e.alu_use_carry = ins[14]; e.alu_in_mux = ins[17];
            add_cyc(3'd2, e, 1'b0);
            w = e; w.reg_write = 1'b1; w.write_c = 1'b1; w.write_z = 1'b1;
            add_cyc(3'd4, w, 1'b0);
        end else if (ins[18:16] == 3'b110) begin
            add_cyc(3'd2, e, 1'b0);
            w = '0; w.reg_write = 1'b1; w.reg_write_mux = 2'b01;
            w.select_c = 1'b1; w.select_z = 1'b1; w.write_c = 1'b1; w.write_z = 1'b1;
            add_cyc(3'd4, w, 1'b0);
        end else if (ins[18:16] == 3'b100) begin
            e.alu_in_mux = 1'b1; e.reg_B_mux = 1'b1;
            add_cyc(3'd2, e, 1'b0);
            for (int k = 0; k < mem_cycles; k++) begin
                m = e;
                if (ins[14]) m.mem_write = 1'b1; else m.mem_read = 1'b1;
                add_cyc(3'd3, m, (k == mem_cycles - 1));
            end
            if (!ins[14]) begin
                w = '0; w.reg_write = 1'b1; w.reg_write_mux = 2'b10;
                add_cyc(3'd4, w, 1'b0);
            end
        end else if (ins[18:16] == 3'b101) begin
            taken = ins[15] ? c : z;
            if (ins[14]) taken = !taken;
            if (taken) begin e.pc_write = 1'b1; e.pc_mux = 2'b01; end
            add_cyc(3'd2, e, 1'b0);
        end else begin
            if (ins[18:14] == 5'b11100) begin
                e.pc_write = 1'b1; e.pc_mux = 2'b10;
            end else if (ins[18:14] == 5'b11101) begin
                if (m_depth == 8) m_err = 1'b1;
                else begin m_depth++; e.pc_write = 1'b1; e.pc_mux = 2'b10; e.push = 1'b1; end
            end else if (ins[18:13] == 6'b111100) begin
                if (m_depth == 0) m_err = 1'b1;
                else begin m_depth--; e.pc_write = 1'b1; e.pc_mux = 2'b11; e.pop = 1'b1; end
            end
            add_cyc(3'd2, e, 1'b0);
        end
    endtask

    // ---------------- driver ----------------
    // Entered #1 after the edge that put the DUT in FETCH.
    task automatic run_instr(input logic [18:0] ins, input logic c, input logic z,
                             input int mem_cycles, input int exp_cycles, input string name);
        cyc_t r;
        int   n;
        model_instr(ins, c, z, mem_cycles);
        instruction = ins; C = c; Z = z;
        n = 0;
        do begin
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                mem_ready = (r.st == 3'd3) ? r.ready : 1'($urandom_range(0, 1));
                check($sformatf("%s_cyc%0d", name, n),
                      {7'd0, state, stack_err, dut_ctl()}, {7'd0, r.st, r.err, r.ctl});
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
                checks++; errors++;
                $display("FAIL %s_extra_cycle: got state %0d expected return to FETCH", name, state);
            end
            n++;
            @(posedge clk); #1;
        end while (state != 3'd0 && n < 50);
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got state %0d after 50 cycles expected FETCH", name, state);
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s_short: got %0d cycles expected %0d more", name, n, exp_q.size());
            exp_q.delete();
        end
        if (exp_cycles > 0) check({name, "_len"}, n, exp_cycles);
    endtask

    // ---------------- stimulus ----------------
    vec_t vecs[11];
    localparam logic [18:0] JSB_I = 19'b11101_00000000000000;
    localparam logic [18:0] RET_I = 19'b111100_0000000000000;

    initial begin
        vecs[0]  = '{19'b0000001100101000000,  1'b0, 1'b0, 1, 4, "add_reg"};
        vecs[1]  = '{19'b00001_00000000000011, 1'b1, 1'b0, 1, 4, "addc_reg"};
        vecs[2]  = '{19'b01110_00000000000101, 1'b0, 1'b1, 1, 4, "arith_imm"};
        vecs[3]  = '{19'b11010_00000000000000, 1'b1, 1'b1, 1, 4, "shift"};
        vecs[4]  = '{19'b10000_00000000000000, 1'b0, 1'b0, 3, 7, "ldm_wait3"};
        vecs[5]  = '{19'b10001_00000000000000, 1'b0, 1'b0, 1, 4, "stm_fast"};
        vecs[6]  = '{19'b10001_00000000000000, 1'b0, 1'b0, 2, 5, "stm_wait2"};
        vecs[7]  = '{19'b10101_00000000000000, 1'b1, 1'b0, 1, 3, "br_taken"};
        vecs[8]  = '{19'b10101_00000000000000, 1'b0, 1'b1, 1, 3, "br_not_taken"};
        vecs[9]  = '{19'b11100_00000000000000, 1'b0, 1'b0, 1, 3, "jmp"};
        vecs[10] = '{19'b11110_10000000000000, 1'b0, 1'b0, 1, 3, "nop"};

        reset = 1'b0; instruction = '0; C = 1'b0; Z = 1'b0; mem_ready = 1'b0;
        m_depth = 0; m_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {7'd0, state, stack_err, dut_ctl()}, 32'd0);

        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++)
            run_instr(vecs[i].instr, vecs[i].c, vecs[i].z, vecs[i].mem_cycles,
                      vecs[i].exp_cycles, vecs[i].name);

        // nine subroutine calls: the last one overflows
        for (int i = 0; i < 9; i++)
            run_instr(JSB_I, 1'b0, 1'b0, 1, 3, $sformatf("jsb%0d", i));
        check("stack_err_after_overflow", stack_err, 1'b1);
        run_instr(RET_I, 1'b0, 1'b0, 1, 3, "ret_after_overflow");

        // random instructions
        for (int i = 0; i < 40; i++)
            run_instr(19'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(1, 4), 0, $sformatf("rnd%0d", i));

        // reset in the middle of a memory access
        instruction = 19'b10000_00000000000000;
        mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("in_mem_before_reset", {28'd0, state, mem_read}, {28'd0, 3'd3, 1'b1});
        #2 reset = 1'b0;
        #1;
        check("reset_in_mem", {7'd0, state, stack_err, dut_ctl()}, 32'd0);
        exp_q.delete();
        m_depth = 0; m_err = 1'b0;
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        check("fetch_after_release", {27'd0, state, ir_write, pc_write}, {27'd0, 3'd0, 1'b1, 1'b1});

        // return with an empty stack, then confirm the error stays set
        run_instr(RET_I, 1'b0, 1'b0, 1, 3, "ret_empty");
        check("stack_err_underflow", stack_err, 1'b1);
        run_instr(vecs[0].instr, 1'b0, 1'b0, 1, 4, "add_after_err");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
